// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
//   Shared constants, types and modular helpers for the Kyber (q = 3329)
//   arithmetic blocks. Montgomery arithmetic uses R = 2^12.
//
//   Contents:
//     W, Q, QINV           coefficient width, modulus, -Q^-1 mod 2^12
//     R_MOD_Q, R2_MOD_Q    R mod Q and R^2 mod Q (Montgomery conversion)
//     coeff_t              12-bit coefficient
//     bfly_mode_e          butterfly flavour (CT forward, GS inverse)
//     bfly_req_t           one butterfly request (mode, a, b, zeta)
//     mod_add / mod_sub    single-correction modular add / subtract
// -----------------------------------------------------------------------------
package kyber_pkg;

    localparam int W        = 12;
    localparam int Q        = 3329;
    localparam int QINV     = 3327;
    localparam int R_MOD_Q  = 767;
    localparam int R2_MOD_Q = 2385;

    typedef logic [W-1:0] coeff_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bfly_mode_e;

    typedef struct packed {
        bfly_mode_e mode;
        coeff_t     a;
        coeff_t     b;
        coeff_t     zeta;
    } bfly_req_t;

    localparam logic [W:0] Q13 = 13'(Q);

    // (x + y) mod Q for x, y < Q. The sum fits 13 bits; one subtraction
    // is enough to bring it back into range.
    function automatic coeff_t mod_add(input coeff_t x, input coeff_t y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q13)
            s = s - Q13;
        return s[W-1:0];
    endfunction

    // (x - y) mod Q for x, y < Q. A negative difference shows up as bit 12
    // set in the 13-bit two's-complement result; adding Q wraps it back.
    function automatic coeff_t mod_sub(input coeff_t x, input coeff_t y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W])
            d = d + Q13;
        return d[W-1:0];
    endfunction

endpackage

// File: rtl/mont_mul_pipe.sv
// -----------------------------------------------------------------------------
// mont_mul_pipe
//   Three-stage Montgomery multiplier, r = x * z * 2^-12 mod Q, with a
//   global stall enable and a generic sideband that travels alongside the
//   product so the caller can keep per-transaction context aligned.
//
//   Stage 1: T = x * z                      (24b)
//   Stage 2: m = (T[11:0] * QINV)[11:0], T carried
//   Stage 3: u = (T + m*Q) >> 12, one conditional subtract of Q
//
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     en              advance the pipeline (0 = every stage holds)
//     in_valid        operand pair valid
//     in_x, in_z      operands, both < Q for a fully reduced result
//     in_side         caller context, returned unchanged with the result
//     out_valid       result valid
//     out_r           reduced product, < Q for legal operands
//     out_side        context matching out_r
// -----------------------------------------------------------------------------
module mont_mul_pipe
    import kyber_pkg::*;
#(
    parameter int SIDE_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [W-1:0]      in_x,
    input  logic [W-1:0]      in_z,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    output logic [W-1:0]      out_r,
    output logic [SIDE_W-1:0] out_side
);

    localparam int STAGES = 3;

    localparam logic [W-1:0] QINV_C = 12'(QINV);
    localparam logic [2*W:0] Q_ACC  = 25'(Q);
    localparam logic [W:0]   Q_U    = 13'(Q);

    logic [STAGES:1]    vld_pipe;

    logic [2*W-1:0]     t_s2;
    logic [SIDE_W-1:0]  side_s2;

    logic [2*W-1:0]     t_s3;
    logic [W-1:0]       m_s3;
    logic [SIDE_W-1:0]  side_s3;

    coeff_t             r_s4;
    logic [SIDE_W-1:0]  side_s4;

    logic [W-1:0]       m_next;
    logic [2*W:0]       acc;
    logic [W:0]         u;
    coeff_t             r_next;

    always_comb begin
        // Only the low 12 bits of T and of the product matter here, so the
        // multiply is evaluated at 12-bit width.
        m_next = t_s2[W-1:0] * QINV_C;

        // T + m*Q is divisible by 2^12 by construction of m; the shift is
        // exact. With T < Q*2^12 the quotient stays below 2Q.
        acc    = 25'(t_s3) + 25'(m_s3) * Q_ACC;
        u      = 13'(acc >> W);
        r_next = (u >= Q_U) ? 12'(u - Q_U) : u[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            t_s2     <= '0;
            side_s2  <= '0;
            t_s3     <= '0;
            m_s3     <= '0;
            side_s3  <= '0;
            r_s4     <= '0;
            side_s4  <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) begin
                t_s2    <= 24'(in_x) * 24'(in_z);
                side_s2 <= in_side;
            end
            if (vld_pipe[1]) begin
                t_s3    <= t_s2;
                m_s3    <= m_next;
                side_s3 <= side_s2;
            end
            if (vld_pipe[2]) begin
                r_s4    <= r_next;
                side_s4 <= side_s3;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_r     = r_s4;
    assign out_side  = side_s4;

endmodule

// File: rtl/ntt_butterfly_3329.sv
// -----------------------------------------------------------------------------
// ntt_butterfly_3329
//   Pipelined NTT / INTT butterfly for Kyber coefficients mod q = 3329.
//     CT (forward): t = MontMul(b, zeta); x = a + t; y = a - t   (mod Q)
//     GS (inverse): x = a + b; y = MontMul(a - b, zeta)          (mod Q)
//   zeta is given in Montgomery form (z * 2^12 mod Q).
//
//   Register stages (one pair per cycle when out_ready = 1):
//     S0  input capture
//     S1  mode pre-op (GS sum/diff, CT pass-through)
//     S2  T = x * zeta             (mont_mul_pipe)
//     S3  m, T carried             (mont_mul_pipe)
//     S4  reduce                   (mont_mul_pipe)
//     S5  CT post add/sub or GS pass-through into the output registers
//   A pair accepted at edge n is presented with out_valid after edge n+5.
//   The mode bit and the a/sum operand ride the multiplier sideband, so
//   mixed CT/GS streams stay ordered.
//
//   Flow control is a single global stall: while the output holds an
//   unaccepted result every stage freezes and in_ready drops.
//
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     in_valid / in_ready      input handshake
//     in_mode                  0 = CT, 1 = GS
//     in_a, in_b, in_zeta      operands, each < Q
//     out_valid / out_ready    output handshake
//     out_x, out_y             result pair, each < Q
// -----------------------------------------------------------------------------
module ntt_butterfly_3329
    import kyber_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_zeta,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y
);

    localparam int SIDE_W = W + 1;  // {mode, a-or-sum}

    logic              en;

    // S0: captured request
    logic              vld_s0;
    bfly_req_t         req_s0;

    // S1: multiplier operands and sideband
    logic              vld_s1;
    bfly_mode_e        mode_s1;
    coeff_t            mulx_s1;
    coeff_t            zeta_s1;
    coeff_t            side_s1;

    coeff_t            mulx_next;
    coeff_t            side_next;

    // multiplier result
    logic              mm_valid;
    coeff_t            mm_r;
    logic [SIDE_W-1:0] mm_side;

    bfly_mode_e        mm_mode;
    coeff_t            mm_a;
    coeff_t            x_next;
    coeff_t            y_next;

    // A result sitting unaccepted at the output freezes the whole pipe.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // ---------------------------------------------------------------- S0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s0 <= 1'b0;
            req_s0 <= '0;
        end else if (en) begin
            vld_s0 <= in_valid;
            if (in_valid)
                req_s0 <= '{mode: bfly_mode_e'(in_mode), a: in_a, b: in_b, zeta: in_zeta};
        end
    end

    // ---------------------------------------------------------------- S1
    always_comb begin
        mulx_next = req_s0.b;
        side_next = req_s0.a;
        if (req_s0.mode == BF_GS) begin
            mulx_next = mod_sub(req_s0.a, req_s0.b);
            side_next = mod_add(req_s0.a, req_s0.b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1  <= 1'b0;
            mode_s1 <= BF_CT;
            mulx_s1 <= '0;
            zeta_s1 <= '0;
            side_s1 <= '0;
        end else if (en) begin
            vld_s1 <= vld_s0;
            if (vld_s0) begin
                mode_s1 <= req_s0.mode;
                mulx_s1 <= mulx_next;
                zeta_s1 <= req_s0.zeta;
                side_s1 <= side_next;
            end
        end
    end

    // ----------------------------------------------------------- S2..S4
    mont_mul_pipe #(
        .SIDE_W (SIDE_W)
    ) u_mont_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (vld_s1),
        .in_x      (mulx_s1),
        .in_z      (zeta_s1),
        .in_side   ({mode_s1, side_s1}),
        .out_valid (mm_valid),
        .out_r     (mm_r),
        .out_side  (mm_side)
    );

    // ---------------------------------------------------------------- S5
    always_comb begin
        mm_mode = bfly_mode_e'(mm_side[W]);
        mm_a    = mm_side[W-1:0];
        x_next  = mm_a;
        y_next  = mm_r;
        if (mm_mode == BF_CT) begin
            x_next = mod_add(mm_a, mm_r);
            y_next = mod_sub(mm_a, mm_r);
        end
    end

    // Output data only loads with a valid result, so after reset the
    // outputs stay at zero until the first real transaction lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (en) begin
            out_valid <= mm_valid;
            if (mm_valid) begin
                out_x <= x_next;
                out_y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_ntt_butterfly_3329.sv
`timescale 1ns/1ps
module tb_ntt_butterfly_3329;

    localparam int Q    = 3329;
    localparam int RINV = 2704;   // 2^-12 mod 3329  (767 * 2704 = 623*3329 + 1)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic [11:0] in_zeta = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_x;
    logic [11:0] out_y;

    ntt_butterfly_3329 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic mode;
        int   a, b, zeta;
        int   ex, ey;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plain modular reference: MontMul(x, zm) == x * zm * 2^-12 mod Q.
    function automatic int ref_mul(input int x, input int zm);
        return ((x * zm) % Q) * RINV % Q;
    endfunction

    function automatic void ref_bfly(input logic mode, input int a, input int b, input int z,
                                     output int ex, output int ey);
        int t;
        if (mode == 1'b0) begin
            t  = ref_mul(b, z);
            ex = (a + t) % Q;
            ey = (a - t + Q) % Q;
        end else begin
            ex = (a + b) % Q;
            ey = ref_mul((a - b + Q) % Q, z);
        end
    endfunction

    function automatic int modpow(input int base, input int e);
        longint r, bb;
        int     ee;
        r = 1; bb = longint'(base); ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % Q;
            bb = (bb * bb) % Q;
            ee = ee >> 1;
        end
        return int'(r);
    endfunction

    // One isolated transaction with out_ready held high; checks latency 5.
    task automatic send_one(input string name, input logic mode, input int a, input int b,
                            input int z, output int ox, output int oy);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = mode;
        in_a = 12'(a); in_b = 12'(b); in_zeta = 12'(z);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; ox = -1; oy = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k; ox = out_x; oy = out_y;
                break;
            end
        end
        check({name, "_latency"}, lat, 5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ox, oy, ex, ey;
        int exp_x[$], exp_y[$];
        int sent, got;
        logic xin, hold;
        int hx, hy;
        logic pm;
        int pa, pb, pz;

        vecs[0] = '{1'b0,  100,  200,  767,  300, 3229};
        vecs[1] = '{1'b0, 3328,    1,  767,    0, 3327};
        vecs[2] = '{1'b0,    5,    7,    0,    5,    5};
        vecs[3] = '{1'b1,    5,   10,  767,   15, 3324};
        vecs[4] = '{1'b1, 3328, 3328,  767, 3327,    0};
        vecs[5] = '{1'b0,    0,    0,  100,    0,    0};
        vecs[6] = '{1'b0, 3328, 3328,  767, 3327,    0};
        vecs[7] = '{1'b1,    0,    1,  767,    1, 3328};
        vecs[8] = '{1'b0, 1000, 3328, 1534,  998, 1002};
        vecs[9] = '{1'b1,    7,    3, 1534,   10,    8};

        // ---- reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed table
        for (int i = 0; i < 10; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].zeta, ox, oy);
            check($sformatf("vec%0d_x", i), ox, vecs[i].ex);
            check($sformatf("vec%0d_y", i), oy, vecs[i].ey);
        end

        // ---- 64 random mixed-mode pairs, random backpressure
        sent = 0; got = 0; xin = 1'b0; hold = 1'b0; hx = 0; hy = 0;
        pm = 1'b0; pa = 0; pb = 0; pz = 0;
        for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
            @(posedge clk); #1;
            if (in_valid && xin) in_valid = 1'b0;
            if (!in_valid && sent < 64 && $urandom_range(0, 3) != 0) begin
                pm = 1'($urandom_range(0, 1));
                pa = int'($urandom_range(0, Q-1));
                pb = int'($urandom_range(0, Q-1));
                pz = int'($urandom_range(0, Q-1));
                in_valid = 1'b1; in_mode = pm;
                in_a = 12'(pa); in_b = 12'(pb); in_zeta = 12'(pz);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("stall_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_x", int'(out_x), hx);
                check("hold_y", int'(out_y), hy);
            end
            hold = out_valid && !out_ready;
            hx = out_x; hy = out_y;
            xin = in_valid && in_ready;
            if (xin) begin
                ref_bfly(pm, pa, pb, pz, ex, ey);
                exp_x.push_back(ex);
                exp_y.push_back(ey);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_x.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    check("stream_x", int'(out_x), exp_x.pop_front());
                    check("stream_y", int'(out_y), exp_y.pop_front());
                end
                got++;
            end
        end
        check("stream_count", got, 64);
        check("stream_leftover", exp_x.size(), 0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);

        // ---- reset with 3 transactions in flight
        #1;
        in_valid = 1'b1; in_mode = 1'b0; in_a = 12'd100; in_b = 12'd200; in_zeta = 12'd767;
        @(posedge clk); #1;
        in_a = 12'd1;
        @(posedge clk); #1;
        in_a = 12'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", int'(out_valid), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", int'(out_valid), 0);
            check("idle_x", int'(out_x), 0);
            check("idle_y", int'(out_y), 0);
        end
        send_one("postrst", 1'b1, 5, 10, 767, ox, oy);
        check("postrst_x", ox, 15);
        check("postrst_y", oy, 3324);

        // ---- CT then GS with inverse twiddle recovers (2a, 2b)
        for (int i = 0; i < 4; i++) begin
            int a, b, zp, zi, zm, zim, x1, y1;
            a   = int'($urandom_range(0, Q-1));
            b   = int'($urandom_range(0, Q-1));
            zp  = int'($urandom_range(1, Q-1));
            zi  = modpow(zp, Q-2);
            zm  = (zp * 4096) % Q;
            zim = (zi * 4096) % Q;
            send_one("rt_ct", 1'b0, a, b, zm, x1, y1);
            send_one("rt_gs", 1'b1, x1, y1, zim, ox, oy);
            check("roundtrip_x", ox, (2 * a) % Q);
            check("roundtrip_y", oy, (2 * b) % Q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly_3329.md
Name: ntt_butterfly_3329

Overview:
Pipelined NTT/INTT butterfly for Kyber coefficients mod q=3329. It is the direct consumer of the Montgomery reduction datapath (R=2^12).
- Accepts one coefficient pair plus a twiddle (zeta, in Montgomery form) per cycle over a valid/ready handshake.
- Applies a Cooley-Tukey (forward) or Gentleman-Sande (inverse) butterfly and streams the result pair out in order.
- Sits between the polynomial RAM read sequencer and the write-back sequencer.

Parameters:
- Q, 3329, modulus
- QINV, 3327, -Q^-1 mod 2^12
- W, 12, coefficient width
- LATENCY, 5, accept-to-out_valid cycles (fixed, not user-tunable)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept this cycle
- in_mode  in  1  0=CT (forward), 1=GS (inverse)
- in_a  in  12  coefficient a, must be < Q
- in_b  in  12  coefficient b, must be < Q
- in_zeta  in  12  twiddle z*2^12 mod Q, must be < Q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_x  out  12  first result, < Q
- out_y  out  12  second result, < Q

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All stage valid bits, out_valid, out_x and out_y go to 0 on reset. in_ready is 1 out of reset.
- MontMul(x,z):
  - T = x*z (24b)
  - m = (T[11:0]*QINV)[11:0]
  - u = (T + m*Q) >> 12, kept 13b
  - result = u - Q if u >= Q, else u
- CT mode:
  - t = MontMul(b, zeta)
  - out_x = (a + t) mod Q
  - out_y = (a - t) mod Q
- GS mode:
  - out_x = (a + b) mod Q
  - out_y = MontMul((a - b) mod Q, zeta)
- Modular add/sub: single conditional correction. Sum ≥ Q subtracts Q; difference < 0 adds Q. Use a 13b intermediate.
- Pipeline, each stage carrying valid, mode, the a/sum sideband and intermediates:
  - S1: mode pre-op (GS computes sum/diff; CT passes through)
  - S2: T register
  - S3: m register, with T carried
  - S4: reduce
  - S5: CT post add/sub or GS pass-through, landing in output registers
- Latency: a transfer accepted at edge n gives out_valid=1 after edge n+5, provided out_ready was held high.
- Throughput: 1 pair/cycle when out_ready=1.
- Handshake:
  - Transfer on valid&&ready at either port.
  - in_ready = !(out_valid && !out_ready). This is a global stall: while stalled, all stages hold.
  - out_x, out_y and out_valid stay stable while out_valid && !out_ready.
- Bubbles: stage valids propagate 0, with no spurious out_valid. Data registers of invalid stages may hold stale values; out_x/out_y are don't-care while out_valid=0.
- Mode can change every transaction. Mode travels with the data, so mixed CT/GS streams stay ordered and correct.
- Boundaries:
  - zeta=0 gives t=0.
  - a = b = Q-1 is legal.
  - No result may ever be ≥ Q.
- Reset mid-stream: all in-flight transactions are discarded; nothing is emitted after rst_n deasserts until new input is accepted.
- Inputs ≥ Q are illegal. Results for them are unspecified, but the block must not hang.

Decomposition:
- Shared package kyber_pkg:
  - Q, QINV, W, R_MOD_Q=767, R2_MOD_Q=2385
  - typedef coeff_t = logic [11:0]
  - enum bfly_mode_e {BF_CT, BF_GS}
  - functions mod_add and mod_sub
- Sub-module mont_mul_pipe: 3-stage (S2–S4) Montgomery multiplier with stall enable, valid and a generic sideband pass-through. It is reusable by pointwise multiplication.

Test Plan:
- CT, a=100, b=200, zeta=767 (z=1) -> out_x=300, out_y=3229 after exactly 5 cycles.
- CT, a=3328, b=1, zeta=767 -> out_x=0, out_y=3327. Also CT, a=5, b=7, zeta=0 -> out_x=5, out_y=5.
- GS, a=5, b=10, zeta=767 -> out_x=15, out_y=3324. Then GS, a=3328, b=3328, zeta=767 -> out_x=3327, out_y=0.
- Back-to-back 64 random mixed-mode pairs with out_ready toggled randomly:
  - outputs match the reference model in order, none lost or duplicated;
  - out_x/out_y stable during stalls;
  - in_ready=0 exactly when out_valid && !out_ready.
- Assert rst_n low with 3 transactions in flight, release, idle 10 cycles -> out_valid stays 0 and outputs read 0. The next accepted pair emits correctly at latency 5.
- Random CT then GS on the same pair with z and its inverse twiddle (scaled so the round trip is identity) -> recovers (2a, 2b) mod Q.
